// File: rtl/sdram_refresh_handler.sv
// SDRAM refresh handler: queues refresh interrupts, arbitrates for the command bus,
// then issues PRECHARGE-ALL followed by one or more AUTO REFRESH commands.
module sdram_refresh_handler #(
    parameter int T_RP        = 3,
    parameter int T_RFC       = 9,
    parameter int MAX_PENDING = 8,
    parameter int PEND_W      = 4,
    parameter int TMR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ref_int,
    input  logic              ref_grant,
    output logic              ref_req,
    output logic              ref_busy,
    output logic [2:0]        cmd,
    output logic              a10,
    output logic              ref_done,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_AREF = 3'b001;

    localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
    localparam logic [TMR_W-1:0]  TMR_ZERO  = TMR_W'(0);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    // Wait states are entered one cycle after the command, hence the load of T-2.
    localparam logic [TMR_W-1:0]  RP_LOAD   = TMR_W'((T_RP  > 1) ? T_RP  - 2 : 0);
    localparam logic [TMR_W-1:0]  RFC_LOAD  = TMR_W'((T_RFC > 1) ? T_RFC - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_PRE      = 3'd2,
        S_WAIT_RP  = 3'd3,
        S_AREF     = 3'd4,
        S_WAIT_RFC = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    typedef struct packed {
        logic       req;
        logic       busy;
        logic       done;
        logic [2:0] cmd;
        logic       a10;
    } out_t;

    state_t            state_r;
    logic [TMR_W-1:0]  timer_r;
    out_t              out_r;
    logic [PEND_W-1:0] pend_nxt_s;
    logic              ovf_set_s;
    logic              dec_s;

    // Moore output pattern presented while the FSM sits in state s.
    function automatic out_t outs_for(input state_t s);
        out_t o;
        o = '{req: 1'b0, busy: 1'b0, done: 1'b0, cmd: CMD_NOP, a10: 1'b0};
        case (s)
            S_REQ:      o.req = 1'b1;
            S_PRE:      begin o.req = 1'b1; o.busy = 1'b1; o.cmd = CMD_PRE; o.a10 = 1'b1; end
            S_WAIT_RP:  begin o.req = 1'b1; o.busy = 1'b1; end
            S_AREF:     begin o.req = 1'b1; o.busy = 1'b1; o.cmd = CMD_AREF; end
            S_WAIT_RFC: begin o.req = 1'b1; o.busy = 1'b1; end
            S_DONE:     begin o.busy = 1'b1; o.done = 1'b1; end
            default:    o.req = 1'b0;
        endcase
        return o;
    endfunction

    assign {ref_req, ref_busy, ref_done, cmd, a10} = out_r;
    assign dec_s = (state_r == S_AREF);

    // Next pending count; a coincident request and issue cancel, even when full.
    always_comb begin
        pend_nxt_s = pending;
        ovf_set_s  = 1'b0;
        if (ref_int && !dec_s) begin
            if (pending == PEND_MAX) begin
                ovf_set_s = 1'b1;
            end else begin
                pend_nxt_s = pending + PEND_ONE;
            end
        end else if (!ref_int && dec_s) begin
            pend_nxt_s = pending - PEND_ONE;
        end else begin
            pend_nxt_s = pending;
        end
    end

    // Pending counter and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= PEND_ZERO;
            overflow <= 1'b0;
        end else begin
            pending  <= pend_nxt_s;
            overflow <= overflow | ovf_set_s;
        end
    end

    // Refresh sequencer with registered outputs taken from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            timer_r <= TMR_ZERO;
            out_r   <= outs_for(S_IDLE);
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (pending != PEND_ZERO) begin
                        state_r <= S_REQ;
                        out_r   <= outs_for(S_REQ);
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (ref_grant) begin
                        state_r <= S_PRE;
                        out_r   <= outs_for(S_PRE);
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_PRE: begin
                    if (T_RP == 1) begin
                        state_r <= S_AREF;
                        out_r   <= outs_for(S_AREF);
                    end else begin
                        state_r <= S_WAIT_RP;
                        timer_r <= RP_LOAD;
                        out_r   <= outs_for(S_WAIT_RP);
                    end
                end
                S_WAIT_RP: begin
                    if (timer_r == TMR_ZERO) begin
                        state_r <= S_AREF;
                        out_r   <= outs_for(S_AREF);
                    end else begin
                        timer_r <= timer_r - TMR_ONE;
                    end
                end
                S_AREF: begin
                    if (T_RFC != 1) begin
                        state_r <= S_WAIT_RFC;
                        timer_r <= RFC_LOAD;
                        out_r   <= outs_for(S_WAIT_RFC);
                    end else if (pend_nxt_s != PEND_ZERO) begin
                        state_r <= S_AREF;
                        out_r   <= outs_for(S_AREF);
                    end else begin
                        state_r <= S_DONE;
                        out_r   <= outs_for(S_DONE);
                    end
                end
                S_WAIT_RFC: begin
                    // Banks are still closed, so further refreshes skip the precharge.
                    if (timer_r != TMR_ZERO) begin
                        timer_r <= timer_r - TMR_ONE;
                    end else if (pending != PEND_ZERO) begin
                        state_r <= S_AREF;
                        out_r   <= outs_for(S_AREF);
                    end else begin
                        state_r <= S_DONE;
                        out_r   <= outs_for(S_DONE);
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    out_r   <= outs_for(S_IDLE);
                end
                default: begin
                    state_r <= S_IDLE;
                    timer_r <= TMR_ZERO;
                    out_r   <= outs_for(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_refresh_handler.sv
// Scoreboard bench: an event-schedule model predicts REQ/PRE/AREF/DONE events with
// their cycle stamps; a monitor pops and compares whenever the DUT shows one.
module tb_sdram_refresh_handler;

    localparam int T_RP = 3;
    localparam int T_RFC = 9;
    localparam int MAXP = 8;
    localparam int K_REQ = 1, K_PRE = 2, K_AREF = 3, K_DONE = 4, K_BAD = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ref_int = 1'b0;
    logic       ref_grant = 1'b0;
    logic       ref_req, ref_busy, a10, ref_done, overflow;
    logic [2:0] cmd;
    logic [3:0] pending;

    sdram_refresh_handler #(.T_RP(T_RP), .T_RFC(T_RFC), .MAX_PENDING(MAXP), .PEND_W(4), .TMR_W(8)) dut (
        .clk(clk), .reset(reset), .ref_int(ref_int), .ref_grant(ref_grant),
        .ref_req(ref_req), .ref_busy(ref_busy), .cmd(cmd), .a10(a10),
        .ref_done(ref_done), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind; int edge_no; int pend; int a10; int req; int busy; int ovf;
    } exp_t;
    exp_t q[$];

    int passed = 0, total = 0;
    int edge_cnt = 0;
    int pend_m = 0, ovf_m = 0, mode_m = 0;
    int aref_e = -100, pre_e = -100, next_aref = -1, next_dec = -1;
    int n_pre = 0, n_aref = 0, n_done = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic push(input int k);
        exp_t e;
        e.kind = k; e.edge_no = edge_cnt; e.pend = pend_m; e.ovf = ovf_m;
        e.a10  = (k == K_PRE) ? 1 : 0;
        e.req  = (k == K_DONE) ? 0 : 1;
        e.busy = (k == K_REQ) ? 0 : 1;
        q.push_back(e);
    endtask

    // Reference model: pending count plus scheduled command times (mode 0 idle,
    // 1 requesting, 2 sequence running, 3 finishing).
    initial begin
        int pend_old;
        bit dec;
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (reset) begin
                pend_m = 0; ovf_m = 0; mode_m = 0;
                aref_e = -100; pre_e = -100; next_aref = -1; next_dec = -1;
                q.delete();
            end else begin
                pend_old = pend_m;
                dec = (aref_e == edge_cnt - 1);
                if (ref_int && !dec) begin
                    if (pend_m == MAXP) ovf_m = 1;
                    else pend_m++;
                end else if (!ref_int && dec) begin
                    pend_m--;
                end
                case (mode_m)
                    0: if (pend_old != 0) begin mode_m = 1; push(K_REQ); end
                    1: if (ref_grant) begin
                        mode_m = 2; pre_e = edge_cnt; next_aref = edge_cnt + T_RP; next_dec = -1;
                        push(K_PRE);
                    end
                    2: if (edge_cnt == next_aref || (edge_cnt == next_dec && pend_old != 0)) begin
                        aref_e = edge_cnt; next_aref = -1; next_dec = edge_cnt + T_RFC;
                        push(K_AREF);
                    end else if (edge_cnt == next_dec) begin
                        mode_m = 3; push(K_DONE);
                    end
                    default: mode_m = 0;
                endcase
            end
        end
    end

    // Monitor: classify what the DUT presents and compare against the queue head.
    initial begin
        bit prev_req = 1'b0;
        int kind;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                kind = 0;
                if (cmd == 3'b010) kind = K_PRE;
                else if (cmd == 3'b001) kind = K_AREF;
                else if (cmd != 3'b111 || a10) kind = K_BAD;
                else if (ref_done) kind = K_DONE;
                else if (ref_req && !prev_req) kind = K_REQ;
                if (kind == K_PRE) n_pre++;
                if (kind == K_AREF) n_aref++;
                if (kind == K_DONE) n_done++;
                if (kind != 0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_event", kind, 0);
                    end else begin
                        e = q.pop_front();
                        chk("ev_kind", kind, e.kind);
                        chk("ev_cycle", edge_cnt, e.edge_no);
                        chk("ev_pending", int'(pending), e.pend);
                        chk("ev_a10", int'(a10), e.a10);
                        chk("ev_req", int'(ref_req), e.req);
                        chk("ev_busy", int'(ref_busy), e.busy);
                        chk("ev_overflow", int'(overflow), e.ovf);
                    end
                end
            end
            prev_req = ref_req;
        end
    end

    task automatic pulse();
        ref_int = 1'b1;
        @(negedge clk);
        ref_int = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((mode_m != 0 || pend_m != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int p0, a0, d0, n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_cmd", int'(cmd), 7);
        chk("reset_pending", int'(pending), 0);

        // Single refresh with grant tied high.
        ref_grant = 1'b1;
        p0 = n_pre; a0 = n_aref; d0 = n_done;
        pulse();
        drain("t2_drain", 200);
        chk("t2_pre", n_pre - p0, 1);
        chk("t2_aref", n_aref - a0, 1);
        chk("t2_done", n_done - d0, 1);

        // Batch of three held off by grant.
        ref_grant = 1'b0;
        p0 = n_pre; a0 = n_aref; d0 = n_done;
        repeat (3) begin pulse(); @(negedge clk); end
        repeat (3) @(negedge clk);
        chk("t3_pending_held", int'(pending), 3);
        chk("t3_req_held", int'(ref_req), 1);
        ref_grant = 1'b1;
        drain("t3_drain", 300);
        chk("t3_pre", n_pre - p0, 1);
        chk("t3_aref", n_aref - a0, 3);
        chk("t3_done", n_done - d0, 1);
        chk("t3_pending_end", int'(pending), 0);

        // Saturation.
        ref_grant = 1'b0;
        repeat (9) pulse();
        @(negedge clk);
        chk("t4_pending_sat", int'(pending), 8);
        chk("t4_overflow", int'(overflow), 1);
        ref_grant = 1'b1;
        drain("t4_drain", 600);
        chk("t4_overflow_sticky", int'(overflow), 1);
        chk("t4_pending_end", int'(pending), 0);

        // Asynchronous reset in the middle of the T_RFC wait.
        pulse();
        n = 0;
        while (!(mode_m == 2 && aref_e > 0 && edge_cnt == aref_e + 3) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("t1_reach_wait_rfc", int'(n < 100), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        q.delete();
        #1;
        chk("t1_cmd", int'(cmd), 7);
        chk("t1_a10", int'(a10), 0);
        chk("t1_req", int'(ref_req), 0);
        chk("t1_pending", int'(pending), 0);
        chk("t1_overflow", int'(overflow), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t1_idle_req", int'(ref_req), 0);
            chk("t1_idle_cmd", int'(cmd), 7);
        end

        // Request coinciding with the AREF cycle.
        p0 = n_pre; a0 = n_aref;
        pulse();
        n = 0;
        while (!(mode_m == 2 && aref_e == edge_cnt) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("t5_reach_aref", int'(n < 100), 1);
        chk("t5_pending_at_aref", int'(pending), 1);
        pulse();
        chk("t5_pending_coincide", int'(pending), 1);
        drain("t5_drain", 200);
        chk("t5_pre", n_pre - p0, 1);
        chk("t5_aref", n_aref - a0, 2);

        // Grant dropped during the precharge wait.
        d0 = n_done;
        pulse();
        n = 0;
        while (!(mode_m == 2 && edge_cnt == pre_e + 1) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("t6_reach_wait_rp", int'(n < 100), 1);
        ref_grant = 1'b0;
        drain("t6_drain", 200);
        chk("t6_done", n_done - d0, 1);

        // Randomized traffic with a wandering grant.
        ref_grant = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            ref_int = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) ref_grant = ~ref_grant;
            @(negedge clk);
        end
        ref_int = 1'b0;
        ref_grant = 1'b1;
        drain("rand_drain", 1000);
        chk("queue_empty", q.size(), 0);
        chk("rand_pending_end", int'(pending), 0);
        chk("rand_overflow", int'(overflow), ovf_m);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
